// File: rtl/lcd_pkg.sv
// ---- lcd_pkg: shared states, timing defaults and error indices for the 4-bit LCD bus (rev 1.0) ----
`default_nettype none

package lcd_pkg;

  typedef enum logic [2:0] {
    WAIT_HI = 3'd0,
    HIGH_HI = 3'd1,
    GAP_NIB = 3'd2,
    HIGH_LO = 3'd3,
    GAP_CMD = 3'd4
  } lcd_state_t;

  localparam int DEF_MIN_SETUP   = 2;
  localparam int DEF_MIN_PULSE   = 12;
  localparam int DEF_MIN_HOLD    = 1;
  localparam int DEF_MIN_NIB_GAP = 50;
  localparam int DEF_MIN_CMD_GAP = 2000;
  localparam int DEF_TIMEOUT     = 4095;

  localparam int CNT_W = 12;

  localparam int ERR_SETUP   = 0;
  localparam int ERR_PULSE   = 1;
  localparam int ERR_HOLD    = 2;
  localparam int ERR_GAP     = 3;
  localparam int ERR_TIMEOUT = 4;
  localparam int ERR_RW      = 5;
  localparam int ERR_W       = 6;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_bus_sampler.sv
// ---- lcd_bus_sampler: input registers, E edge detection, bus stability counter (rev 1.0) ----
`default_nettype none

module lcd_bus_sampler
  import lcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             lcd_e,
  input  logic             lcd_rs,
  input  logic             lcd_rw,
  input  logic [3:0]       sf_d,
  output logic             e_q,
  output logic             rw_q,
  output logic             rise,
  output logic             fall,
  output logic             rd_changed,
  output logic [CNT_W-1:0] stable_cnt,
  output logic [3:0]       lat_d,
  output logic             lat_rs
);

  logic       e_q2;
  logic       rs_q;
  logic [3:0] d_q;

  assign rise = e_q & ~e_q2;
  assign fall = ~e_q & e_q2;

  // rd_changed and stable_cnt both describe the registered bus value, not the raw pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q        <= 1'b0;
      e_q2       <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      d_q        <= 4'h0;
      rd_changed <= 1'b0;
      stable_cnt <= '0;
      lat_d      <= 4'h0;
      lat_rs     <= 1'b0;
    end else begin
      e_q        <= lcd_e;
      e_q2       <= e_q;
      rs_q       <= lcd_rs;
      rw_q       <= lcd_rw;
      d_q        <= sf_d;
      rd_changed <= ({lcd_rs, sf_d} != {rs_q, d_q});
      if ({lcd_rs, lcd_rw, sf_d} != {rs_q, rw_q, d_q})
        stable_cnt <= '0;
      else
        stable_cnt <= sat_inc(stable_cnt);
      if (e_q) begin
        lat_d  <= d_q;
        lat_rs <= rs_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_nibble_receiver.sv
// ---- lcd_nibble_receiver: reassembles 4-bit LCD writes into bytes and flags timing violations (rev 1.0) ----
`default_nettype none

module lcd_nibble_receiver
  import lcd_pkg::*;
#(
  parameter int MIN_SETUP   = DEF_MIN_SETUP,
  parameter int MIN_PULSE   = DEF_MIN_PULSE,
  parameter int MIN_HOLD    = DEF_MIN_HOLD,
  parameter int MIN_NIB_GAP = DEF_MIN_NIB_GAP,
  parameter int MIN_CMD_GAP = DEF_MIN_CMD_GAP,
  parameter int TIMEOUT     = DEF_TIMEOUT
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             lcd_e,
  input  logic             lcd_rs,
  input  logic             lcd_rw,
  input  logic [3:0]       sf_d,
  input  logic             clear_err,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             rx_rs,
  output logic             nibble_phase,
  output logic [ERR_W-1:0] err
);

  logic             e_q, rw_q, rise, fall, rd_changed, lat_rs;
  logic [CNT_W-1:0] stable_cnt;
  logic [3:0]       lat_d;

  lcd_bus_sampler u_sampler (
    .clk        (clk),
    .reset      (reset),
    .lcd_e      (lcd_e),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .sf_d       (sf_d),
    .e_q        (e_q),
    .rw_q       (rw_q),
    .rise       (rise),
    .fall       (fall),
    .rd_changed (rd_changed),
    .stable_cnt (stable_cnt),
    .lat_d      (lat_d),
    .lat_rs     (lat_rs)
  );

  lcd_state_t       state;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [3:0]       hi_nib;
  logic             hi_rs;

  logic [CNT_W:0]   elapsed;
  logic             in_gap;
  logic             accept;
  logic             timeout_hit;
  logic [ERR_W-1:0] err_set;

  // elapsed counts the fall cycle itself, so a gap of N low cycles reads N at the next rise
  always_comb begin
    elapsed     = {1'b0, gap_cnt} + 1'b1;
    in_gap      = (state == GAP_NIB) || (state == GAP_CMD);
    accept      = rise && !rw_q;
    timeout_hit = (state == GAP_NIB) && !accept && (gap_cnt == CNT_W'(TIMEOUT));
    err_set     = '0;
    err_set[ERR_SETUP]   = (rise && (stable_cnt < CNT_W'(MIN_SETUP))) ||
                           (fall && (state == HIGH_LO) && (lat_rs != hi_rs));
    err_set[ERR_PULSE]   = fall && (hi_cnt < CNT_W'(MIN_PULSE));
    err_set[ERR_HOLD]    = rd_changed &&
                           (e_q || fall || (in_gap && (elapsed < (CNT_W+1)'(MIN_HOLD))));
    err_set[ERR_GAP]     = accept &&
                           (((state == GAP_NIB) && (elapsed < (CNT_W+1)'(MIN_NIB_GAP))) ||
                            ((state == GAP_CMD) && (elapsed < (CNT_W+1)'(MIN_CMD_GAP))));
    err_set[ERR_TIMEOUT] = timeout_hit;
    err_set[ERR_RW]      = rise && rw_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= WAIT_HI;
      hi_cnt       <= '0;
      gap_cnt      <= '0;
      hi_nib       <= 4'h0;
      hi_rs        <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= 8'h00;
      rx_rs        <= 1'b0;
      nibble_phase <= 1'b0;
      err          <= '0;
    end else begin
      rx_valid <= 1'b0;
      hi_cnt   <= e_q ? sat_inc(hi_cnt) : '0;
      gap_cnt  <= fall ? '0 : sat_inc(gap_cnt);
      // a violation detected in the clearing cycle survives the clear
      err      <= (clear_err ? '0 : err) | err_set;
      case (state)
        WAIT_HI: begin
          if (accept) state <= HIGH_HI;
        end
        HIGH_HI: begin
          if (fall) begin
            hi_nib       <= lat_d;
            hi_rs        <= lat_rs;
            nibble_phase <= 1'b1;
            state        <= GAP_NIB;
          end
        end
        GAP_NIB: begin
          if (accept) begin
            state <= HIGH_LO;
          end else if (timeout_hit) begin
            nibble_phase <= 1'b0;
            state        <= WAIT_HI;
          end
        end
        HIGH_LO: begin
          if (fall) begin
            rx_data      <= {hi_nib, lat_d};
            rx_rs        <= lat_rs;
            rx_valid     <= 1'b1;
            nibble_phase <= 1'b0;
            state        <= GAP_CMD;
          end
        end
        GAP_CMD: begin
          if (accept) state <= HIGH_HI;
        end
        default: begin
          nibble_phase <= 1'b0;
          state        <= WAIT_HI;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_nibble_receiver.sv
// ---- tb_lcd_nibble_receiver: scoreboard bench driving 4-bit LCD writes into lcd_nibble_receiver (rev 1.0) ----
`default_nettype none

module tb_lcd_nibble_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic [3:0] sf_d = 4'h0;
  logic       clear_err = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_rs;
  logic       nibble_phase;
  logic [5:0] err;

  int total = 0;
  int bad = 0;
  logic [8:0] sb[$];

  lcd_nibble_receiver dut (
    .clk          (clk),
    .reset        (reset),
    .lcd_e        (lcd_e),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .sf_d         (sf_d),
    .clear_err    (clear_err),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_rs        (rx_rs),
    .nibble_phase (nibble_phase),
    .err          (err)
  );

  always #10 clk = ~clk;

  // every rx_valid must match the oldest byte still owed
  always @(negedge clk) begin
    if (rx_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rx_unexpected: got rs=%0b data=%h, no byte expected", rx_rs, rx_data);
      end else begin
        logic [8:0] exp;
        exp = sb.pop_front();
        if ({rx_rs, rx_data} !== exp) begin
          bad++;
          $display("FAIL rx_byte: got rs=%0b data=%h, want rs=%0b data=%h",
                   rx_rs, rx_data, exp[8], exp[7:0]);
        end
      end
    end
  end

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // called on a negedge where E is low; E stays low for gap cycles with data set 2 before the rise
  task automatic send_nibble(input logic rs, input logic [3:0] d, input int gap,
                             input int pulse, input bit hold_bad);
    repeat (gap - 2) @(negedge clk);
    lcd_rs = rs;
    lcd_rw = 1'b0;
    sf_d   = d;
    repeat (2) @(negedge clk);
    lcd_e = 1'b1;
    repeat (pulse) @(negedge clk);
    lcd_e = 1'b0;
    if (hold_bad) sf_d = ~d;
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] data, input int cmd_gap,
                           input int hi_pulse, input bit hi_hold_bad);
    sb.push_back({rs, data});
    send_nibble(rs, data[7:4], cmd_gap, hi_pulse, hi_hold_bad);
    send_nibble(rs, data[3:0], 50, 12, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({rx_valid, rx_data, rx_rs} !== 10'h0) begin
      bad++;
      $display("FAIL reset_rx: got valid=%0b data=%h rs=%0b, want 0", rx_valid, rx_data, rx_rs);
    end
    total++;
    if ({nibble_phase, err} !== 7'h0) begin
      bad++;
      $display("FAIL reset_status: got phase=%0b err=%b, want 0", nibble_phase, err);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cmd();
    send_byte(1'b0, 8'h38, 10, 12, 1'b0);
    drain();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL cmd_received: pending=%0d, want 0", sb.size());
    end
    total++;
    if (err !== 6'b000000) begin
      bad++;
      $display("FAIL cmd_err: got %b, want 000000", err);
    end
  endtask

  task automatic test_back_to_back();
    send_byte(1'b1, 8'h41, 2000, 12, 1'b0);
    drain();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_received: pending=%0d, want 0", sb.size());
    end
    total++;
    if (err !== 6'b000000) begin
      bad++;
      $display("FAIL b2b_err: got %b, want 000000", err);
    end
  endtask

  task automatic test_short_cmd_gap();
    send_byte(1'b1, 8'h41, 1500, 12, 1'b0);
    drain();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL gap_received: pending=%0d, want 0", sb.size());
    end
    total++;
    if (err !== 6'b001000) begin
      bad++;
      $display("FAIL gap_err: got %b, want 001000", err);
    end
    pulse_clear();
    total++;
    if (err !== 6'b000000) begin
      bad++;
      $display("FAIL gap_clear: got %b, want 000000", err);
    end
  endtask

  task automatic test_short_pulse();
    send_byte(1'b0, 8'h5A, 2000, 8, 1'b0);
    drain();
    total++;
    if (err !== 6'b000010) begin
      bad++;
      $display("FAIL pulse_err: got %b, want 000010", err);
    end
    pulse_clear();
    total++;
    if (err !== 6'b000000) begin
      bad++;
      $display("FAIL pulse_clear: got %b, want 000000", err);
    end
  endtask

  task automatic test_hold();
    send_byte(1'b1, 8'hC3, 2000, 12, 1'b1);
    drain();
    total++;
    if (err !== 6'b000100) begin
      bad++;
      $display("FAIL hold_err: got %b, want 000100", err);
    end
    pulse_clear();
  endtask

  task automatic test_timeout();
    send_nibble(1'b0, 4'h7, 2000, 12, 1'b0);
    repeat (4000) @(negedge clk);
    total++;
    if ({nibble_phase, err[4]} !== 2'b10) begin
      bad++;
      $display("FAIL timeout_early: got phase=%0b err4=%0b, want phase=1 err4=0",
               nibble_phase, err[4]);
    end
    for (int i = 0; i < 300 && err[4] !== 1'b1; i++) @(negedge clk);
    total++;
    if (err !== 6'b010000) begin
      bad++;
      $display("FAIL timeout_err: got %b, want 010000", err);
    end
    total++;
    if (nibble_phase !== 1'b0) begin
      bad++;
      $display("FAIL timeout_phase: got %0b, want 0", nibble_phase);
    end
    pulse_clear();
  endtask

  task automatic test_reset_mid_byte();
    send_nibble(1'b1, 4'h4, 20, 12, 1'b0);
    repeat (20) @(negedge clk);
    total++;
    if (nibble_phase !== 1'b1) begin
      bad++;
      $display("FAIL midreset_phase: got %0b, want 1", nibble_phase);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send_byte(1'b0, 8'h01, 10, 12, 1'b0);
    drain();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL midreset_received: pending=%0d, want 0", sb.size());
    end
    total++;
    if (err !== 6'b000000) begin
      bad++;
      $display("FAIL midreset_err: got %b, want 000000", err);
    end
  endtask

  initial begin
    test_reset();
    test_cmd();
    test_back_to_back();
    test_short_cmd_gap();
    test_short_pulse();
    test_hold();
    test_timeout();
    test_reset_mid_byte();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
